// File: rtl/pipeline_reg_nslot.sv
// N-slot elastic pipeline register for valid/backpressure channels.
// A circular buffer with an optional same-cycle bypass when empty and synchronous flush.
module pipeline_reg_nslot #(
  parameter string       Name   = "",
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 2,
  parameter bit          Bypass = 1'b0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [Width-1:0]           d,
  input  logic                       d_valid,
  output logic                       d_bp,
  output logic [Width-1:0]           q,
  output logic                       q_valid,
  input  logic                       q_bp,
  input  logic                       flush,
  output logic [$clog2(Depth+1)-1:0] occupancy
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic empty, full, bypass_path;
  logic incoming, outgoing, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(Depth));
  assign bypass_path = Bypass && empty;

  // Backpressure looks only at local state, never at q_bp, so bp paths are cut here.
  assign d_bp      = flush | full;
  assign q_valid   = bypass_path ? (d_valid & ~flush) : (~empty & ~flush);
  assign q         = bypass_path ? d : mem_q[rd_ptr_q];
  assign occupancy = count_q;

  assign incoming = d_valid & ~d_bp;
  assign outgoing = q_valid & ~q_bp;
  // A bypassed token that leaves immediately is never written.
  assign push     = incoming & ~(bypass_path & outgoing);
  assign pop      = outgoing & ~bypass_path;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only visible once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= d;
  end

endmodule

// File: tb/tb_pipeline_reg_nslot.sv
// Bench for pipeline_reg_nslot: three configurations share one stimulus stream and
// are checked every cycle against a queue model, plus directed literal expectations.
module tb_pipeline_reg_nslot;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] d;
  logic       d_valid, q_bp, flush;

  // Instance 0: Depth=3 Bypass=0, 1: Depth=3 Bypass=1, 2: Depth=1 Bypass=0
  logic       d_bp0, d_bp1, d_bp2;
  logic       qv0, qv1, qv2;
  logic [7:0] q0, q1, q2;
  logic [1:0] occ0, occ1;
  logic [0:0] occ2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipeline_reg_nslot #(.Name("d3"), .Width(8), .Depth(3), .Bypass(1'b0)) u_d3 (
    .clk(clk), .resetn(resetn), .d(d), .d_valid(d_valid), .d_bp(d_bp0),
    .q(q0), .q_valid(qv0), .q_bp(q_bp), .flush(flush), .occupancy(occ0));

  pipeline_reg_nslot #(.Name("d3b"), .Width(8), .Depth(3), .Bypass(1'b1)) u_d3b (
    .clk(clk), .resetn(resetn), .d(d), .d_valid(d_valid), .d_bp(d_bp1),
    .q(q1), .q_valid(qv1), .q_bp(q_bp), .flush(flush), .occupancy(occ1));

  pipeline_reg_nslot #(.Name("d1"), .Width(8), .Depth(1), .Bypass(1'b0)) u_d1 (
    .clk(clk), .resetn(resetn), .d(d), .d_valid(d_valid), .d_bp(d_bp2),
    .q(q2), .q_valid(qv2), .q_bp(q_bp), .flush(flush), .occupancy(occ2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: each configuration is an ordered list of stored tokens.
  int unsigned depth_c [3] = '{3, 3, 1};
  bit          byp_c   [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0]  mq [3][$];

  function automatic void model_out(input int k, output bit ev, output bit ebp,
                                    output logic [7:0] eq);
    int sz = mq[k].size();
    ebp = flush || (sz == int'(depth_c[k]));
    eq  = 8'h00;
    if (byp_c[k] && sz == 0) begin
      ev = d_valid && !flush;
      eq = d;
    end else begin
      ev = (sz != 0) && !flush;
      if (sz != 0) eq = mq[k][0];
    end
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit ev, ebp, acc, leave, thru;
        logic [7:0] eq;
        model_out(k, ev, ebp, eq);
        acc   = d_valid && !ebp;
        leave = ev && !q_bp;
        thru  = byp_c[k] && mq[k].size() == 0;
        if (flush) mq[k].delete();
        else begin
          if (leave && !thru) void'(mq[k].pop_front());
          if (acc && !(thru && leave)) mq[k].push_back(d);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      logic       av [3];
      logic       abp[3];
      logic [7:0] aq [3];
      logic [1:0] ao [3];
      av  = '{qv0, qv1, qv2};
      abp = '{d_bp0, d_bp1, d_bp2};
      aq  = '{q0, q1, q2};
      ao  = '{occ0, occ1, {1'b0, occ2}};
      for (int k = 0; k < 3; k++) begin
        bit ev, ebp;
        logic [7:0] eq;
        model_out(k, ev, ebp, eq);
        check($sformatf("u%0d q_valid", k), 32'(av[k]), 32'(ev));
        check($sformatf("u%0d d_bp", k), 32'(abp[k]), 32'(ebp));
        check($sformatf("u%0d occupancy", k), 32'(ao[k]), 32'(mq[k].size()));
        if (ev) check($sformatf("u%0d q", k), 32'(aq[k]), 32'(eq));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    logic [6:0] wrap_bp;
    resetn = 1'b0; d = 8'h00; d_valid = 1'b0; q_bp = 1'b0; flush = 1'b0;
    #13;
    check("reset q_valid", 32'(qv0), 32'd0);
    check("reset d_bp", 32'(d_bp0), 32'd0);
    check("reset occupancy", 32'(occ0), 32'd0);
    #10 resetn = 1'b1;
    step();

    // Fill then drain
    q_bp = 1'b1; d_valid = 1'b1;
    d = 8'h11; step();
    d = 8'h22; step();
    d = 8'h33; step();
    d_valid = 1'b0; #1;
    check("fill d_bp", 32'(d_bp0), 32'd1);
    check("fill occupancy", 32'(occ0), 32'd3);
    q_bp = 1'b0; #1;
    check("drain q_valid 0", 32'(qv0), 32'd1);
    check("drain q 0", 32'(q0), 32'h11);
    step();
    check("drain q 1", 32'(q0), 32'h22);
    step();
    check("drain q 2", 32'(q0), 32'h33);
    step();
    check("drain empty", 32'(qv0), 32'd0);

    // Streaming: one token per cycle, one cycle latency
    d_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'(i);
      step();
      check($sformatf("stream q_valid %0d", i), 32'(qv0), 32'd1);
      check($sformatf("stream q %0d", i), 32'(q0), 32'(i));
      check($sformatf("stream occ %0d", i), 32'(occ0 <= 2'd1), 32'd1);
    end
    d_valid = 1'b0; step();

    // Pointer wrap under irregular backpressure
    wrap_bp = 7'b1001101;
    d_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      d = 8'h40 + 8'(i);
      q_bp = wrap_bp[i];
      step();
    end
    d_valid = 1'b0; q_bp = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("wrap drained", 32'(occ0), 32'd0);

    // Bypass with empty buffer
    d = 8'hA5; d_valid = 1'b1; q_bp = 1'b0; #1;
    check("bypass q_valid", 32'(qv1), 32'd1);
    check("bypass q", 32'(q1), 32'hA5);
    check("bypass occ", 32'(occ1), 32'd0);
    step();
    check("bypass occ after", 32'(occ1), 32'd0);
    q_bp = 1'b1; #1;
    step();
    check("bypass stored occ", 32'(occ1), 32'd1);

    // Flush with two stored tokens and an offered input
    d_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0; q_bp = 1'b1; d_valid = 1'b1;
    d = 8'h55; step();
    d = 8'h66; step();
    check("pre-flush occ", 32'(occ0), 32'd2);
    flush = 1'b1; d = 8'h77; #1;
    check("flush d_bp", 32'(d_bp0), 32'd1);
    check("flush q_valid", 32'(qv0), 32'd0);
    step();
    flush = 1'b0; d_valid = 1'b0; #1;
    check("post-flush occ", 32'(occ0), 32'd0);
    check("post-flush q_valid", 32'(qv0), 32'd0);

    // Asynchronous reset arriving with the clock edge while full
    d_valid = 1'b1;
    d = 8'h81; step();
    d = 8'h82; step();
    d = 8'h83; step();
    d_valid = 1'b0;
    check("pre-reset occ", 32'(occ0), 32'd3);
    @(posedge clk);
    resetn = 1'b0;
    #1;
    check("async reset q_valid", 32'(qv0), 32'd0);
    check("async reset d_bp", 32'(d_bp0), 32'd0);
    check("async reset occ", 32'(occ0), 32'd0);
    #2 resetn = 1'b1;
    q_bp = 1'b0;
    step();

    // Depth=1 under a continuous stream accepts every other cycle
    acc1 = 0;
    d_valid = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      d = 8'hC0 + 8'(i);
      #1;
      if (!d_bp2) acc1++;
      step();
    end
    check("depth1 throughput", 32'(acc1), 32'd5);
    d_valid = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
